// File: rtl/prog_mem_arbiter_if.sv
// Bundle of requester and program-memory signals around prog_mem_arbiter.
// The arbiter uses the slave modport; requesters and memory use the master modport.
interface prog_mem_arbiter_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 32
);
  // fetch side
  logic                      f_req_i;
  logic [MEM_ADDR_WIDTH-1:0] f_addr_i;
  logic                      f_gnt_o;
  logic                      f_rvalid_o;
  logic [DATA_WIDTH-1:0]     f_rdata_o;
  // loader side
  logic                      l_req_i;
  logic                      l_we_i;
  logic [MEM_ADDR_WIDTH-1:0] l_addr_i;
  logic [DATA_WIDTH-1:0]     l_wdata_i;
  logic                      l_gnt_o;
  logic                      l_rvalid_o;
  logic [DATA_WIDTH-1:0]     l_rdata_o;
  logic                      err_o;
  // memory side
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i,
    input  l_req_i, l_we_i, l_addr_i, l_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o,
    output l_gnt_o, l_rvalid_o, l_rdata_o, err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output f_req_i, f_addr_i,
    output l_req_i, l_we_i, l_addr_i, l_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o,
    input  l_gnt_o, l_rvalid_o, l_rdata_o, err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory port between fetch and loader,
// one outstanding transaction. Define PROG_ARB_TIMEOUT_EN to add a response watchdog.
module prog_mem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 32
`ifdef PROG_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog_mem_arbiter_if.slave    bus
);

  localparam int unsigned AW = MEM_ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;
  typedef enum logic       {FETCH, LOADER}               owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          last_q, last_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            resp_done;
  logic            resp_err;
  logic [DW-1:0]   resp_data;
  logic            arb_en;
  logic            win_loader;

`ifdef PROG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;

  // Cycles spent in WAIT_RVALID without a memory response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != WAIT_RVALID) begin
      cnt_q <= '0;
    end else if (!bus.mem_rvalid_i && !timeout) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout   = (state_q == WAIT_RVALID) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign resp_done = bus.mem_rvalid_i | timeout;
  assign resp_err  = timeout & ~bus.mem_rvalid_i;
`else
  assign resp_done = bus.mem_rvalid_i;
  assign resp_err  = 1'b0;
`endif

  assign resp_data  = bus.mem_rvalid_i ? bus.mem_rdata_i : '0;
  // On contention the loader wins only if fetch won last time
  assign win_loader = bus.l_req_i & (~bus.f_req_i | (last_q == FETCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= FETCH;
      last_q      <= LOADER;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    arb_en         = 1'b0;
    bus.f_gnt_o    = 1'b0;
    bus.l_gnt_o    = 1'b0;
    bus.f_rvalid_o = 1'b0;
    bus.l_rvalid_o = 1'b0;
    bus.f_rdata_o  = '0;
    bus.l_rdata_o  = '0;
    bus.err_o      = 1'b0;

    case (state_q)
      IDLE: arb_en = 1'b1;
      WAIT_GNT: begin
        if (bus.mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (resp_done) begin
          arb_en     = 1'b1;
          state_d    = IDLE;
          bus.err_o  = resp_err;
          if (owner_q == LOADER) begin
            bus.l_rvalid_o = 1'b1;
            bus.l_rdata_o  = resp_data;
          end else begin
            bus.f_rvalid_o = 1'b1;
            bus.f_rdata_o  = resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the winner's request only at grant time
    if (arb_en && (bus.f_req_i || bus.l_req_i)) begin
      state_d   = WAIT_GNT;
      mem_req_d = 1'b1;
      if (win_loader) begin
        bus.l_gnt_o = 1'b1;
        mem_we_d    = bus.l_we_i;
        mem_addr_d  = bus.l_addr_i;
        mem_wdata_d = bus.l_wdata_i;
        owner_d     = LOADER;
        last_d      = LOADER;
      end else begin
        bus.f_gnt_o = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.f_addr_i;
        mem_wdata_d = '0;
        owner_d     = FETCH;
        last_d      = FETCH;
      end
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter; timeout scenario built when PROG_ARB_TIMEOUT_EN is defined.
module tb_prog_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  prog_mem_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.f_req_i      = 1'b0;
    bus.f_addr_i     = '0;
    bus.l_req_i      = 1'b0;
    bus.l_we_i       = 1'b0;
    bus.l_addr_i     = '0;
    bus.l_wdata_i    = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic drain();
    bus.f_req_i = 1'b0; bus.l_req_i = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1;
    repeat (3) @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [113:0] outs;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    outs = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.f_gnt_o, bus.l_gnt_o,
            bus.f_rvalid_o, bus.l_rvalid_o, bus.err_o, bus.f_rdata_o, bus.l_rdata_o};
    if (outs !== '0) begin $display("FAIL reset_outputs: got %h want 0", outs); bad++; end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 10'h004;
    #1;
    if (bus.f_gnt_o !== 1'b1) begin $display("FAIL fr_f_gnt: got %b want 1", bus.f_gnt_o); bad++; end
    total++;
    if (bus.l_gnt_o !== 1'b0) begin $display("FAIL fr_l_gnt: got %b want 0", bus.l_gnt_o); bad++; end
    total++;
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o} !== {1'b1, 1'b0, 10'h004}) begin
      $display("FAIL fr_mem_req: got req=%b we=%b addr=%h want 1 0 004", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
      bad++;
    end
    total++;
    if (bus.f_gnt_o !== 1'b0) begin $display("FAIL fr_gnt_pulse: got %b want 0", bus.f_gnt_o); bad++; end
    total++;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
    #1;
    if ({bus.f_rvalid_o, bus.f_rdata_o} !== {1'b1, 32'h0000_0013}) begin
      $display("FAIL fr_rvalid: got v=%b d=%h want 1 00000013", bus.f_rvalid_o, bus.f_rdata_o); bad++;
    end
    total++;
    if ({bus.l_rvalid_o, bus.l_rdata_o, bus.err_o} !== '0) begin
      $display("FAIL fr_loader_quiet: got v=%b d=%h err=%b want 0", bus.l_rvalid_o, bus.l_rdata_o, bus.err_o); bad++;
    end
    total++;
    if (bus.mem_req_o !== 1'b0) begin $display("FAIL fr_mem_req_drop: got %b want 0", bus.mem_req_o); bad++; end
    total++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (bus.f_rvalid_o !== 1'b0) begin $display("FAIL fr_rvalid_pulse: got %b want 0", bus.f_rvalid_o); bad++; end
    total++;
  endtask

  task automatic test_stray_rvalid();
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_AAAA;
    #1;
    if ({bus.f_rvalid_o, bus.l_rvalid_o, bus.f_rdata_o, bus.l_rdata_o} !== '0) begin
      $display("FAIL stray_outputs: got fv=%b lv=%b fd=%h ld=%h want 0",
               bus.f_rvalid_o, bus.l_rvalid_o, bus.f_rdata_o, bus.l_rdata_o);
      bad++;
    end
    total++;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0; bus.f_req_i = 1'b1; bus.f_addr_i = 10'h044;
    #1;
    if ({bus.f_gnt_o, bus.mem_req_o} !== 2'b10) begin
      $display("FAIL stray_still_idle: got gnt=%b mem_req=%b want 1 0", bus.f_gnt_o, bus.mem_req_o); bad++;
    end
    total++;
    drain();
  endtask

  task automatic test_contention();
    logic [6:0] exp_fg, exp_lg, exp_fr, exp_lr;
    exp_fg = 7'b0010001;
    exp_lg = 7'b1000100;
    exp_fr = 7'b1000100;
    exp_lr = 7'b0010000;
    test_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus.f_req_i = 1'b1; bus.f_addr_i = 10'h008;
      bus.l_req_i = 1'b1; bus.l_we_i = 1'b0; bus.l_addr_i = 10'h020;
      bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
      #1;
      if (bus.f_gnt_o !== exp_fg[c]) begin
        $display("FAIL rr_f_gnt c%0d: got %b want %b", c, bus.f_gnt_o, exp_fg[c]); bad++;
      end
      total++;
      if (bus.l_gnt_o !== exp_lg[c]) begin
        $display("FAIL rr_l_gnt c%0d: got %b want %b", c, bus.l_gnt_o, exp_lg[c]); bad++;
      end
      total++;
      if (bus.f_rvalid_o !== exp_fr[c]) begin
        $display("FAIL rr_f_rvalid c%0d: got %b want %b", c, bus.f_rvalid_o, exp_fr[c]); bad++;
      end
      total++;
      if (bus.l_rvalid_o !== exp_lr[c]) begin
        $display("FAIL rr_l_rvalid c%0d: got %b want %b", c, bus.l_rvalid_o, exp_lr[c]); bad++;
      end
      total++;
      if (c == 1 && bus.mem_addr_o !== 10'h008) begin
        $display("FAIL rr_addr_fetch: got %h want 008", bus.mem_addr_o); bad++;
      end
      if (c == 1) total++;
      if (c == 3 && {bus.mem_addr_o, bus.mem_we_o} !== {10'h020, 1'b0}) begin
        $display("FAIL rr_addr_loader: got %h we=%b want 020 0", bus.mem_addr_o, bus.mem_we_o); bad++;
      end
      if (c == 3) total++;
    end
    drain();
  endtask

  task automatic test_loader_write_stall();
    @(negedge clk);
    bus.l_req_i = 1'b1; bus.l_we_i = 1'b1; bus.l_addr_i = 10'h010; bus.l_wdata_i = 32'hDEAD_BEEF;
    #1;
    if ({bus.l_gnt_o, bus.f_gnt_o} !== 2'b10) begin
      $display("FAIL lw_gnt: got l=%b f=%b want 1 0", bus.l_gnt_o, bus.f_gnt_o); bad++;
    end
    total++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.l_req_i = 1'b0; bus.l_addr_i = 10'(c * 3); bus.l_wdata_i = 32'(c);
      bus.mem_gnt_i = (c == 4);
      #1;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF}) begin
        $display("FAIL lw_stable c%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 010 deadbeef",
                 c, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        bad++;
      end
      total++;
    end
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
    #1;
    if ({bus.l_rvalid_o, bus.err_o, bus.f_rvalid_o, bus.mem_req_o} !== 4'b1000) begin
      $display("FAIL lw_resp: got lv=%b err=%b fv=%b mem_req=%b want 1 0 0 0",
               bus.l_rvalid_o, bus.err_o, bus.f_rvalid_o, bus.mem_req_o);
      bad++;
    end
    total++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_txn();
    logic [113:0] outs;
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 10'h3FC;
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    outs = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.f_gnt_o, bus.l_gnt_o,
            bus.f_rvalid_o, bus.l_rvalid_o, bus.err_o, bus.f_rdata_o, bus.l_rdata_o};
    if (outs !== '0) begin $display("FAIL rst_mid_outputs: got %h want 0", outs); bad++; end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555_5555;
    #1;
    if ({bus.f_rvalid_o, bus.l_rvalid_o, bus.err_o} !== 3'b000) begin
      $display("FAIL rst_mid_stray: got fv=%b lv=%b err=%b want 0 0 0", bus.f_rvalid_o, bus.l_rvalid_o, bus.err_o);
      bad++;
    end
    total++;
    @(negedge clk);
    idle_inputs();
    #1;
    if (bus.mem_req_o !== 1'b0) begin $display("FAIL rst_mid_mem_req: got %b want 0", bus.mem_req_o); bad++; end
    total++;
  endtask

`ifdef PROG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    bus.f_req_i = 1'b1; bus.f_addr_i = 10'h100;
    #1;
    if (bus.f_gnt_o !== 1'b1) begin $display("FAIL to_gnt: got %b want 1", bus.f_gnt_o); bad++; end
    total++;
    @(negedge clk);
    bus.f_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0; bus.mem_rdata_i = 32'hCAFE_0000;
      #1;
      if (k < 16 && bus.f_rvalid_o !== 1'b0) begin
        $display("FAIL to_early k%0d: got %b want 0", k, bus.f_rvalid_o); bad++;
      end
      if (k < 16) total++;
      if (k == 16 && {bus.f_rvalid_o, bus.err_o, bus.f_rdata_o, bus.l_rvalid_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        $display("FAIL to_pulse: got fv=%b err=%b fd=%h lv=%b want 1 1 0 0",
                 bus.f_rvalid_o, bus.err_o, bus.f_rdata_o, bus.l_rvalid_o);
        bad++;
      end
      if (k == 16) total++;
    end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1;
    #1;
    if ({bus.f_rvalid_o, bus.err_o, bus.mem_req_o} !== 3'b000) begin
      $display("FAIL to_late_rvalid: got fv=%b err=%b mem_req=%b want 0 0 0", bus.f_rvalid_o, bus.err_o, bus.mem_req_o);
      bad++;
    end
    total++;
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_stray_rvalid();
    test_contention();
    test_loader_write_stall();
    test_reset_mid_txn();
`ifdef PROG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
